// File: rtl/ccff_loader.sv
// Configuration-chain loader: shifts a sentinel then CHAIN_LEN bitstream bits
// into the fabric chain, and checks that the sentinel emerges at ccff_tail.
module ccff_loader #(
  parameter int          CHAIN_LEN = 64,
  parameter int          SENT_LEN  = 8,
  parameter logic [31:0] SENTINEL  = 32'h000000A5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cfg_bit,
  input  logic cfg_valid,
  output logic cfg_ready,
  output logic ccff_head,
  output logic prog_en,
  input  logic ccff_tail,
  output logic fabric_reset,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int TOTAL = CHAIN_LEN + SENT_LEN;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SENT,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_n;
  logic          r_mismatch;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic          r_fabric_reset;

  logic [31:0] w_n32;
  logic [4:0]  w_sent_idx;
  logic [4:0]  w_chk_idx;
  logic        w_in_window;
  logic        w_exp_tail;
  logic        w_tail_bad;
  logic        w_last_sent;
  logic        w_last_load;

  assign w_n32       = 32'(r_n);
  assign w_sent_idx  = 5'(r_n);
  assign w_chk_idx   = 5'(w_n32 - 32'(CHAIN_LEN));
  assign w_in_window = (w_n32 >= 32'(CHAIN_LEN)) && (w_n32 < 32'(TOTAL));
  assign w_exp_tail  = SENTINEL[w_chk_idx];
  // Case inequality so an X on the tail (open chain) counts as a mismatch.
  assign w_tail_bad  = prog_en && w_in_window && (ccff_tail !== w_exp_tail);
  assign w_last_sent = (r_n == CW'(SENT_LEN - 1));
  assign w_last_load = (r_n == CW'(TOTAL - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // state leaves one unassigned and no latch is inferred.
  always_comb begin
    prog_en   = 1'b0;
    cfg_ready = 1'b0;
    ccff_head = 1'b0;
    case (r_state)
      S_SENT: begin
        prog_en   = 1'b1;
        ccff_head = SENTINEL[w_sent_idx];
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        prog_en   = cfg_valid;
        ccff_head = cfg_bit;
      end
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_n            <= '0;
      r_mismatch     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_fabric_reset <= 1'b1;
    end else begin
      if (prog_en)    r_n        <= r_n + CW'(1);
      if (w_tail_bad) r_mismatch <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_state    <= S_SENT;
          r_n        <= '0;
          r_mismatch <= 1'b0;
          r_busy     <= 1'b1;
        end
        S_SENT: if (w_last_sent) r_state <= S_LOAD;
        S_LOAD: if (prog_en && w_last_load) begin
          r_busy <= 1'b0;
          // The final shift's own comparison is folded in here.
          if (r_mismatch || w_tail_bad) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_fabric_reset <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign fabric_reset = r_fabric_reset;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a 16/15-bit chain model, directed loads, and a
// scoreboard of expected end-of-load results checked by a separate monitor.
module tb_ccff_loader;

  localparam int          CHAIN = 16;
  localparam int          SLEN  = 8;
  localparam logic [31:0] SENT  = 32'h000000A5;

  logic clk = 1'b0;
  logic reset, start, cfg_bit, cfg_valid;
  logic cfg_ready, ccff_head, prog_en, ccff_tail;
  logic fabric_reset, busy, done, error;

  ccff_loader #(.CHAIN_LEN(CHAIN), .SENT_LEN(SLEN), .SENTINEL(SENT)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .prog_en(prog_en), .ccff_tail(ccff_tail), .fabric_reset(fabric_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Fabric chain model; chain[0] is the first flip-flop.
  logic [15:0] chain = '0;
  int          chain_len = 16;
  bit          stuck0 = 1'b0;
  int          n_shifts = 0;
  int          n_acc = 0;

  assign ccff_tail = stuck0 ? 1'b0 : chain[chain_len-1];

  always @(posedge clk) begin
    if (prog_en) chain <= {chain[14:0], ccff_head};
    if (reset) begin
      n_shifts <= 0;
      n_acc    <= 0;
    end else begin
      if (prog_en)               n_shifts <= n_shifts + 1;
      if (cfg_ready && cfg_valid) n_acc   <= n_acc + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        done;
    logic        error;
    logic        frst;
    int          shifts;
    int          accepted;
    logic [15:0] chain;
    bit          chk_chain;
  } exp_t;

  exp_t sb[$];

  task automatic compare_end();
    exp_t e;
    check("sb_has_entry", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("end_done",         done,         e.done);
      check("end_error",        error,        e.error);
      check("end_fabric_reset", fabric_reset, e.frst);
      check("end_shifts",       n_shifts,     e.shifts);
      check("end_accepted",     n_acc,        e.accepted);
      if (e.chk_chain) check("end_chain", chain, e.chain);
    end
  endtask

  // Monitor: one scoreboard pop each time a load finishes.
  logic prev_end  = 1'b0;
  logic prev_frst = 1'b1;
  always @(negedge clk) begin
    if ((done || error) && !prev_end) begin
      compare_end();
      check("frst_high_on_last_shift", prev_frst, 1);
    end
    prev_end  <= done || error;
    prev_frst <= fabric_reset;
  end

  task automatic push(input logic d, input logic er, input logic fr,
                      input logic [15:0] ch, input bit chk);
    exp_t e;
    e.done = d; e.error = er; e.frst = fr; e.shifts = CHAIN + SLEN;
    e.accepted = CHAIN; e.chain = ch; e.chk_chain = chk;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("in_reset", {prog_en, cfg_ready, ccff_head, busy, done, error, fabric_reset}, 7'b0000001);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset", {prog_en, cfg_ready, ccff_head, busy, done, error, fabric_reset}, 7'b0000001);
  endtask

  // Data is sent MSB first so a 16-bit chain ends up reading as the word.
  task automatic run_load(input logic [15:0] data, input bit toggle,
                          input bit poke_start, input int abort_at);
    int idx = 0;
    bit v = 1'b0, acc = 1'b0, poked = 1'b0, ended = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("sent_head_bit0", {busy, ccff_head, prog_en}, {2'b11, 1'b1});
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (acc) idx++;
      if (done || error) begin ended = 1'b1; break; end
      if (abort_at > 0 && n_shifts == abort_at) begin
        reset = 1'b1; cfg_valid = 1'b0; ended = 1'b1; break;
      end
      start = poke_start && !poked && idx == 5;
      if (start) poked = 1'b1;
      if (cfg_ready && idx < 16) begin
        v = toggle ? !v : 1'b1;
        cfg_valid = v; cfg_bit = data[15-idx]; acc = v;
      end else begin
        cfg_valid = 1'b0; acc = 1'b0;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0; start = 1'b0;
    check("load_finished", ended, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    do_reset();

    // Clean load with a start pulse injected mid-LOAD, then start in DONE.
    push(1'b1, 1'b0, 1'b0, 16'h3C5A, 1'b1);
    run_load(16'h3C5A, 1'b0, 1'b1, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_ignores_start", {done, busy, error, fabric_reset, prog_en}, 5'b10000);
    check("done_no_extra_shifts", n_shifts, CHAIN + SLEN);

    // Stalled source: cfg_valid alternates during LOAD.
    do_reset();
    push(1'b1, 1'b0, 1'b0, 16'h3C5A, 1'b1);
    run_load(16'h3C5A, 1'b1, 1'b0, 0);

    // Broken chain: one flip-flop short, sentinel arrives a bit early.
    do_reset();
    chain_len = 15;
    push(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
    run_load(16'hF00F, 1'b0, 1'b0, 0);
    chain_len = 16;
    repeat (3) @(negedge clk);
    check("err_persists", {error, done, busy, fabric_reset}, 4'b1001);

    // Tail stuck at 0.
    do_reset();
    stuck0 = 1'b1;
    push(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
    run_load(16'h1234, 1'b0, 1'b0, 0);
    stuck0 = 1'b0;

    // Reset after 10 shifts, then a full reload.
    do_reset();
    run_load(16'hBEEF, 1'b0, 1'b0, 10);
    @(negedge clk);
    check("midload_reset", {prog_en, cfg_ready, busy, done, error, fabric_reset}, 6'b000001);
    reset = 1'b0;
    @(negedge clk);
    push(1'b1, 1'b0, 1'b0, 16'hA5C3, 1'b1);
    run_load(16'hA5C3, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, number of configuration flip-flops in the fabric chain (>=1).
REQ-002 SHALL have parameter SENT_LEN, default 8, sentinel length in bits (1..32).
REQ-003 SHALL have parameter SENTINEL, default 32'h000000A5, sentinel pattern; bit 0 is shifted first.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-007 SHALL have port cfg_bit  input  1  next configuration bit from the bitstream source.
REQ-008 SHALL have port cfg_valid  input  1  cfg_bit is valid.
REQ-009 SHALL have port cfg_ready  output  1  loader accepts cfg_bit this cycle.
REQ-010 SHALL have port ccff_head  output  1  serial data into the fabric configuration chain.
REQ-011 SHALL have port prog_en  output  1  chain shift enable; the chain shifts at a clk edge where prog_en=1.
REQ-012 SHALL have port ccff_tail  input  1  serial output of the last chain flip-flop.
REQ-013 SHALL have port fabric_reset  output  1  holds the user fabric in reset while not configured.
REQ-014 SHALL have ports busy, done, error  output  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, SENT, LOAD, DONE, ERR.
REQ-016 SHALL keep a shift counter n (completed shifts, width ceil(log2(CHAIN_LEN+SENT_LEN+1))), cleared on IDLE->SENT and incremented on every edge with prog_en=1.
REQ-017 IDLE: start=1 -> SENT; start is ignored in every other state.
REQ-018 SENT: prog_en=1, ccff_head=SENTINEL[n], cfg_ready=0; after the shift with n=SENT_LEN-1 -> LOAD.
REQ-019 LOAD: cfg_ready=1, ccff_head=cfg_bit, prog_en=cfg_valid (combinational); cfg_valid=0 stalls with no shift, no counter change.
REQ-020 LOAD: after the shift with n=CHAIN_LEN+SENT_LEN-1 -> DONE if no mismatch was recorded, else ERR.
REQ-021 Check: on every shift cycle with CHAIN_LEN <= n < CHAIN_LEN+SENT_LEN, ccff_tail SHALL be compared with SENTINEL[n-CHAIN_LEN]; any inequality (including X) sets a sticky mismatch flag, cleared on IDLE->SENT.
REQ-022 A mismatch SHALL NOT abort the load; all CHAIN_LEN data bits are always shifted.
REQ-023 Every bit outside the check window SHALL NOT be compared.
REQ-024 prog_en and cfg_ready SHALL be 0 in IDLE, DONE, ERR.
REQ-025 busy=1 exactly in SENT and LOAD; done=1 exactly in DONE; error=1 exactly in ERR.
REQ-026 fabric_reset=1 in all states except DONE; it falls the cycle after the final shift with a clean check.
REQ-027 DONE and ERR SHALL persist until reset; start in DONE/ERR is ignored (reload requires reset).
REQ-028 ccff_head SHALL be 0 in IDLE, DONE, ERR.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, n=0, mismatch=0 regardless of state, including mid-load.
REQ-030 During and after reset until start: prog_en=0, cfg_ready=0, ccff_head=0, busy=0, done=0, error=0, fabric_reset=1.
REQ-031 reset SHALL take priority over start in the same cycle.

Verification (CHAIN_LEN=16, SENT_LEN=8, SENTINEL=8'hA5, bench models a 16-bit shift register)
REQ-032 Clean load: start, 16 bits 0x3C5A with cfg_valid held high -> 24 prog_en cycles, chain holds 0x3C5A in order, done=1, fabric_reset=0 one cycle after the last shift, error=0.
REQ-033 Stalled source: cfg_valid toggled 1/0 each cycle in LOAD -> exactly 24 shifts total, same chain contents, done=1.
REQ-034 Broken chain: bench model of length 15 -> sentinel misaligned, error=1, done=0, fabric_reset stays 1, all 16 data bits still accepted.
REQ-035 Stuck tail: ccff_tail forced 0 -> error=1 after the 24th shift.
REQ-036 Reset mid-load: reset after 10 shifts -> next cycle IDLE, prog_en=0, busy=0; new start replays from sentinel bit 0 and completes with done=1.
REQ-037 Ignored start: pulse start in LOAD and in DONE -> no counter restart, no extra shifts, state unchanged.
